tdc_tap_sweep_ctrl: RTL
=======================

# tdc_tap_sweep_ctrl

Sequencer for TDC delay-line characterisation. It steps the 5-bit tap-select of the 32:1 delay-line mux tree and waits for the mux path to settle after each step. At each tap it issues a fixed number of measurement requests to the TDC platform, averages the returned codes, and hands one result record per tap to the UART packer through a valid/ready handshake. It replaces the free-running tap counter clocked by the sampling pulse with a deterministic, abortable sweep in the `clk10m` domain.

## Interface
- `NTAPS`, 32: number of selectable taps; power of two, 2..256.
- `SEL_W`, 5: tap-select width, equal to log2(`NTAPS`).
- `SAMPLES`, 16: measurements per tap; power of two, 1..256.
- `CODE_W`, 8: TDC code width.
- `SETTLE`, 4: idle cycles after a tap change before the first request; 1..255.
- `TIMEOUT`, 200: cycles to wait for `meas_done` before declaring a miss.

- `clk10m` in 1: sole clock; all logic on its rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: one-cycle pulse; begins a sweep when the block is idle.
- `loop` in 1: sampled at `start`; 1 restarts at tap 0 after the last tap.
- `abort` in 1: level; returns the block to IDLE.
- `tap_sel` out `SEL_W`: drives the mux-tree select.
- `meas_req` out 1: one-cycle pulse requesting one TDC measurement.
- `meas_done` in 1: one-cycle pulse; `meas_code` is valid in the same cycle.
- `meas_code` in `CODE_W`: measured code.
- `meas_ovf` in 1: qualifies `meas_done`; the code is invalid or overranged.
- `res_valid` out 1: result record available.
- `res_ready` in 1: consumer accepts the record.
- `res_tap` out `SEL_W`: tap index of the record.
- `res_avg` out `CODE_W`: averaged code.
- `res_miss` out 9: number of overflow and timeout samples in the record.
- `busy` out 1: high in every state except IDLE.
- `sweep_done` out 1: one-cycle pulse after the final record of a non-loop sweep is accepted.

## Operation
- States: IDLE, SETTLE, REQ, WAIT, ACC, EMIT.
- IDLE:
  - `start` → SETTLE. On the same edge: `tap_sel`=0, accumulator=0, sample count=0, miss count=0, latch `loop`.
  - `start` while busy is ignored.
- SETTLE: counts `SETTLE` cycles, then → REQ.
- REQ:
  - `meas_req`=1 for exactly one cycle, then → WAIT.
  - The timeout counter clears on entry to WAIT.
- WAIT:
  - `meas_done`=1 → ACC. The sample value is `meas_code`, or all-ones (2^`CODE_W`−1) if `meas_ovf`=1, in which case the miss count increments.
  - `TIMEOUT` cycles with no `meas_done` → ACC with an all-ones sample; the miss count increments.
  - A `meas_done` arriving outside WAIT is ignored.
- ACC:
  - Adds the sample into the accumulator, which is `CODE_W`+log2(`SAMPLES`) bits and cannot overflow.
  - Increments the sample count.
  - If the count reaches `SAMPLES` → EMIT; otherwise → REQ. There is no re-settle on the same tap.
- EMIT:
  - `res_valid`=1 with `res_tap`=`tap_sel`, `res_avg`=accumulator >> log2(`SAMPLES`) (truncating), `res_miss`=miss count.
  - The record is held stable until `res_valid`&&`res_ready`.
  - On acceptance, if `tap_sel`<`NTAPS`−1: increment `tap_sel`, clear the accumulator and counters, → SETTLE.
  - On acceptance of the last tap with `loop`=1: `tap_sel`=0, clear the counters, → SETTLE.
  - On acceptance of the last tap with `loop`=0: pulse `sweep_done`, → IDLE. `tap_sel` holds its last value.
- `abort`=1 in any state: → IDLE on the next edge.
  - Drops the pending record, so `res_valid` falls on that edge and no `sweep_done` pulse is produced.
  - `tap_sel` holds its value.
  - `abort` takes priority over `start` in the same cycle.

## Timing
- Reset values:
  - State IDLE; `tap_sel`=0; `meas_req`=0; `res_valid`=0; `res_tap`=0; `res_avg`=0; `res_miss`=0; `busy`=0; `sweep_done`=0.
  - Reset mid-sweep behaves identically.
- All outputs are registered.
- `start` at edge k:
  - `busy`=1 and `tap_sel`=0 after edge k.
  - First `meas_req` high after edge k+`SETTLE`+1.
- Sample turnaround: `meas_done` at edge j → next `meas_req` high after edge j+2 (via ACC, REQ).
- `tap_sel` changes only on leaving EMIT, and never while `meas_req` or WAIT is active.
- Per-tap minimum: `SETTLE` + `SAMPLES`·3 + 1 cycles, plus handshake stall.
- Timeout exactly: WAIT entered at edge w with no done → ACC after edge w+`TIMEOUT`.
- `res_ready` high before `res_valid` rises: acceptance takes one cycle in EMIT.

## Test plan
- Start with `loop`=0, `SAMPLES`=4, TDC model returns code=10+tap with 5-cycle latency, `res_ready`=1 → 32 records, tap 0..31, avg=10+tap, miss=0; one `sweep_done` pulse; `busy` falls on the same edge.
- Codes 3,4,4,4 for one tap → `res_avg`=3 (sum 15 >> 2, truncating).
- No `meas_done` for tap 5 → each sample times out after 200 cycles; record 5 has avg=255, miss=4; other taps unaffected.
- `res_ready` held low for 50 cycles in EMIT → `res_valid` and record fields stable throughout, `tap_sel` unchanged, no `meas_req` issued.
- `abort` during WAIT at tap 7, then `start` → IDLE next edge with no record or `sweep_done`; the restarted sweep begins at tap 0 with cleared accumulator.
- `loop`=1 → after the tap 31 record is accepted, `tap_sel`=0 and SETTLE is re-entered with no `sweep_done` pulse; `start` pulses mid-sweep are ignored.

Source files
------------

// File: rtl/tdc_tap_sweep_ctrl.sv
// rtl/tdc_tap_sweep_ctrl.sv - TDC delay-line tap sweep sequencer with per-tap averaging
module tdc_tap_sweep_ctrl #(
    parameter int NTAPS   = 32,
    parameter int SEL_W   = 5,
    parameter int SAMPLES = 16,
    parameter int CODE_W  = 8,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 200
) (
    input  logic              clk10m,
    input  logic              rst_n,
    input  logic              start,
    input  logic              loop,
    input  logic              abort,
    output logic [SEL_W-1:0]  tap_sel,
    output logic              meas_req,
    input  logic              meas_done,
    input  logic [CODE_W-1:0] meas_code,
    input  logic              meas_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SEL_W-1:0]  res_tap,
    output logic [CODE_W-1:0] res_avg,
    output logic [8:0]        res_miss,
    output logic              busy,
    output logic              sweep_done
);

    localparam int LOG_S = $clog2(SAMPLES);
    localparam int ACC_W = CODE_W + LOG_S;
    localparam int CNT_W = LOG_S + 1;
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [SEL_W-1:0]  LAST_TAP = SEL_W'(NTAPS - 1);
    localparam logic [CNT_W-1:0]  LAST_SMP = CNT_W'(SAMPLES - 1);
    localparam logic [SET_W-1:0]  LAST_SET = SET_W'(SETTLE - 1);
    localparam logic [TMO_W-1:0]  LAST_TMO = TMO_W'(TIMEOUT - 1);
    localparam logic [CODE_W-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_REQ,
        S_WAIT,
        S_ACC,
        S_EMIT
    } state_t;

    state_t            state_q;
    logic [SEL_W-1:0]  tap_q;
    logic              loop_q;
    logic [SET_W-1:0]  set_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [CNT_W-1:0]  smp_cnt_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CODE_W-1:0] sample_q;
    logic [8:0]        miss_q;

    logic              meas_req_q;
    logic              res_valid_q;
    logic [SEL_W-1:0]  res_tap_q;
    logic [CODE_W-1:0] res_avg_q;
    logic [8:0]        res_miss_q;
    logic              busy_q;
    logic              sweep_done_q;

    logic [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]  smp_cnt_d;

    always_comb begin
        acc_d     = acc_q + ACC_W'(sample_q);
        smp_cnt_d = smp_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk10m) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            loop_q       <= 1'b0;
            set_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            smp_cnt_q    <= '0;
            acc_q        <= '0;
            sample_q     <= '0;
            miss_q       <= '0;
            meas_req_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_tap_q    <= '0;
            res_avg_q    <= '0;
            res_miss_q   <= '0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            meas_req_q   <= 1'b0;
            sweep_done_q <= 1'b0;
            if (abort) begin
                // tap_sel deliberately holds so the operator can see where the sweep stopped
                state_q     <= S_IDLE;
                res_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q   <= S_SETTLE;
                            tap_q     <= '0;
                            acc_q     <= '0;
                            smp_cnt_q <= '0;
                            miss_q    <= '0;
                            set_cnt_q <= '0;
                            loop_q    <= loop;
                            busy_q    <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (set_cnt_q == LAST_SET) begin
                            state_q <= S_REQ;
                        end else begin
                            set_cnt_q <= set_cnt_q + SET_W'(1);
                        end
                    end
                    S_REQ: begin
                        meas_req_q <= 1'b1;
                        tmo_cnt_q  <= '0;
                        state_q    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (meas_done) begin
                            sample_q <= meas_ovf ? ALL_ONES : meas_code;
                            if (meas_ovf) begin
                                miss_q <= miss_q + 9'd1;
                            end
                            state_q <= S_ACC;
                        end else if (tmo_cnt_q == LAST_TMO) begin
                            sample_q <= ALL_ONES;
                            miss_q   <= miss_q + 9'd1;
                            state_q  <= S_ACC;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        end
                    end
                    S_ACC: begin
                        acc_q     <= acc_d;
                        smp_cnt_q <= smp_cnt_d;
                        if (smp_cnt_q == LAST_SMP) begin
                            state_q     <= S_EMIT;
                            res_valid_q <= 1'b1;
                            res_tap_q   <= tap_q;
                            res_avg_q   <= acc_d[ACC_W-1:LOG_S];
                            res_miss_q  <= miss_q;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                    S_EMIT: begin
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            acc_q       <= '0;
                            smp_cnt_q   <= '0;
                            miss_q      <= '0;
                            set_cnt_q   <= '0;
                            if (tap_q != LAST_TAP) begin
                                tap_q   <= tap_q + SEL_W'(1);
                                state_q <= S_SETTLE;
                            end else if (loop_q) begin
                                tap_q   <= '0;
                                state_q <= S_SETTLE;
                            end else begin
                                state_q      <= S_IDLE;
                                busy_q       <= 1'b0;
                                sweep_done_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tap_sel    = tap_q;
    assign meas_req   = meas_req_q;
    assign res_valid  = res_valid_q;
    assign res_tap    = res_tap_q;
    assign res_avg    = res_avg_q;
    assign res_miss   = res_miss_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;

endmodule
